// File: rtl/dfd_cla_dst_mmr_apb.sv
// APB register slave for the DFD CLA/DST MMR cluster: ID, scratch, DST control
// and a coherent 64-bit CoreTime snapshot (LO read latches HI).
module dfd_cla_dst_mmr_apb #(
   parameter int          DFD_APB_ADDR_WIDTH  = 23,
   parameter int          DFD_APB_DATA_WIDTH  = 32,
   parameter int          DFD_APB_PSTRB_WIDTH = 4,
   parameter logic [31:0] ID_VALUE            = 32'hDFD0_0001
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic [DFD_APB_ADDR_WIDTH-1:0]  paddr,
   input  logic                           psel,
   input  logic                           penable,
   input  logic [DFD_APB_PSTRB_WIDTH-1:0] pstrb,
   input  logic                           pwrite,
   input  logic [DFD_APB_DATA_WIDTH-1:0]  pwdata,
   output logic                           pready,
   output logic [DFD_APB_DATA_WIDTH-1:0]  prdata,
   output logic                           pslverr,
   input  logic [63:0]                    core_time,
   output logic [DFD_APB_DATA_WIDTH-1:0]  dst_ctrl
);
   localparam int AW = DFD_APB_ADDR_WIDTH;
   localparam int DW = DFD_APB_DATA_WIDTH;

   localparam logic [AW-1:0] ADDR_ID       = AW'(23'h000240);
   localparam logic [AW-1:0] ADDR_SCRATCH0 = AW'(23'h000248);
   localparam logic [AW-1:0] ADDR_SCRATCH1 = AW'(23'h00024C);
   localparam logic [AW-1:0] ADDR_DST_CTRL = AW'(23'h166040);
   localparam logic [AW-1:0] ADDR_CT_LO    = AW'(23'h166048);
   localparam logic [AW-1:0] ADDR_CT_HI    = AW'(23'h16604C);

   logic [DW-1:0] scratch0_q, scratch0_d;
   logic [DW-1:0] scratch1_q, scratch1_d;
   logic [DW-1:0] dst_ctrl_q, dst_ctrl_d;
   logic [31:0]   snap_q, snap_d;

   logic          access, err, wr_en, rd_en;
   logic          hit_id, hit_s0, hit_s1, hit_dst, hit_lo, hit_hi, mapped, ro;
   logic [DW-1:0] wmask, rd_mux;

   assign access  = psel & penable;
   assign hit_id  = (paddr == ADDR_ID);
   assign hit_s0  = (paddr == ADDR_SCRATCH0);
   assign hit_s1  = (paddr == ADDR_SCRATCH1);
   assign hit_dst = (paddr == ADDR_DST_CTRL);
   assign hit_lo  = (paddr == ADDR_CT_LO);
   assign hit_hi  = (paddr == ADDR_CT_HI);
   assign mapped  = hit_id | hit_s0 | hit_s1 | hit_dst | hit_lo | hit_hi;
   assign ro      = hit_id | hit_lo | hit_hi;

   // Full 23-bit decode already rejects misaligned offsets; the explicit term keeps that visible.
   assign err   = ~mapped | (paddr[1:0] != 2'b00) | (pwrite & ro);
   assign wr_en = access & pwrite & ~err;
   assign rd_en = access & ~pwrite & ~err;

   generate
      for (genvar gi = 0; gi < DFD_APB_PSTRB_WIDTH; gi++) begin : g_lane
         assign wmask[gi*8 +: 8] = {8{pstrb[gi]}};
      end
   endgenerate

   always_comb begin
      scratch0_d = scratch0_q;
      scratch1_d = scratch1_q;
      dst_ctrl_d = dst_ctrl_q;
      snap_d     = snap_q;
      if (wr_en && hit_s0)  scratch0_d = (scratch0_q & ~wmask) | (pwdata & wmask);
      if (wr_en && hit_s1)  scratch1_d = (scratch1_q & ~wmask) | (pwdata & wmask);
      if (wr_en && hit_dst) dst_ctrl_d = (dst_ctrl_q & ~wmask) | (pwdata & wmask);
      if (rd_en && hit_lo)  snap_d     = core_time[63:32];
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         scratch0_q <= '0;
         scratch1_q <= '0;
         dst_ctrl_q <= '0;
         snap_q     <= '0;
      end else begin
         scratch0_q <= scratch0_d;
         scratch1_q <= scratch1_d;
         dst_ctrl_q <= dst_ctrl_d;
         snap_q     <= snap_d;
      end
   end

   always_comb begin
      rd_mux = '0;
      unique case (1'b1)
         hit_id:  rd_mux = ID_VALUE;
         hit_s0:  rd_mux = scratch0_q;
         hit_s1:  rd_mux = scratch1_q;
         hit_dst: rd_mux = dst_ctrl_q;
         hit_lo:  rd_mux = core_time[31:0];
         hit_hi:  rd_mux = snap_q;
         default: rd_mux = '0;
      endcase
   end

   assign pready   = access;
   assign pslverr  = access & err;
   assign prdata   = rd_en ? rd_mux : '0;
   assign dst_ctrl = dst_ctrl_q;

endmodule

// File: tb/tb_dfd_cla_dst_mmr_apb.sv
// Directed bench for dfd_cla_dst_mmr_apb: APB reads/writes, strobes, snapshot,
// error responses and reset abort, checked against hand-computed values.
module tb_dfd_cla_dst_mmr_apb;
   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [22:0] paddr = '0;
   logic        psel = 1'b0;
   logic        penable = 1'b0;
   logic [3:0]  pstrb = '0;
   logic        pwrite = 1'b0;
   logic [31:0] pwdata = '0;
   logic        pready;
   logic [31:0] prdata;
   logic        pslverr;
   logic [63:0] core_time = '0;
   logic [31:0] dst_ctrl;

   int checks = 0;
   int failures = 0;
   logic [31:0] dst_at_access;

   dfd_cla_dst_mmr_apb dut (
      .clk(clk), .reset(reset), .paddr(paddr), .psel(psel), .penable(penable),
      .pstrb(pstrb), .pwrite(pwrite), .pwdata(pwdata), .pready(pready),
      .prdata(prdata), .pslverr(pslverr), .core_time(core_time), .dst_ctrl(dst_ctrl)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // Starts and ends just after a rising edge; samples each access cycle on the falling edge.
   task automatic xfer(input string tag, input logic [22:0] a, input logic wr,
                       input logic [31:0] d, input logic [3:0] s, input int hold,
                       output logic [31:0] rd, output logic err);
      paddr = a; pwrite = wr; pwdata = d; pstrb = s; psel = 1'b1; penable = 1'b0;
      #1 chk({tag, "_setup_pready"}, {31'b0, pready}, 32'h0);
      @(posedge clk); #1;
      penable = 1'b1;
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         chk({tag, "_pready"}, {31'b0, pready}, 32'h1);
         rd = prdata; err = pslverr; dst_at_access = dst_ctrl;
         @(posedge clk); #1;
      end
      psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
      $display("xfer %s addr=%h wr=%0b wdata=%h strb=%h prdata=%h pslverr=%0b",
               tag, a, wr, d, s, rd, err);
   endtask

   task automatic rd_chk(input string tag, input logic [22:0] a,
                         input logic [31:0] exp_d, input logic exp_e);
      logic [31:0] r; logic e;
      xfer(tag, a, 1'b0, 32'h0, 4'h0, 1, r, e);
      chk({tag, "_prdata"}, r, exp_d);
      chk({tag, "_pslverr"}, {31'b0, e}, {31'b0, exp_e});
   endtask

   task automatic wr_chk(input string tag, input logic [22:0] a, input logic [31:0] d,
                         input logic [3:0] s, input int hold, input logic exp_e);
      logic [31:0] r; logic e;
      xfer(tag, a, 1'b1, d, s, hold, r, e);
      chk({tag, "_pslverr"}, {31'b0, e}, {31'b0, exp_e});
      chk({tag, "_prdata"}, r, 32'h0);
   endtask

   initial begin
      #12;
      chk("rst_pready", {31'b0, pready}, 32'h0);
      chk("rst_prdata", prdata, 32'h0);
      chk("rst_dst_ctrl", dst_ctrl, 32'h0);
      @(posedge clk); #1;
      reset = 1'b0;
      @(posedge clk); #1;

      rd_chk("rd_s0_rst",  23'h000248, 32'h0, 1'b0);
      rd_chk("rd_s1_rst",  23'h00024C, 32'h0, 1'b0);
      rd_chk("rd_dst_rst", 23'h166040, 32'h0, 1'b0);
      rd_chk("rd_id",      23'h000240, 32'hDFD0_0001, 1'b0);
      rd_chk("rd_cthi_rst",23'h16604C, 32'h0, 1'b0);

      wr_chk("wr_s0_held", 23'h000248, 32'hDEAD_BEEF, 4'hF, 3, 1'b0);
      rd_chk("rd_s0", 23'h000248, 32'hDEAD_BEEF, 1'b0);
      rd_chk("rd_s1", 23'h00024C, 32'h0, 1'b0);

      wr_chk("wr_dst", 23'h166040, 32'hBEEF_DEAD, 4'hF, 1, 1'b0);
      chk("dst_before_edge", dst_at_access, 32'h0);
      chk("dst_after_edge", dst_ctrl, 32'hBEEF_DEAD);
      rd_chk("rd_dst", 23'h166040, 32'hBEEF_DEAD, 1'b0);
      wr_chk("wr_dst_strb5", 23'h166040, 32'h1122_3344, 4'h5, 1, 1'b0);
      chk("dst_strb5", dst_ctrl, 32'hBE22_DE44);
      rd_chk("rd_dst_strb5", 23'h166040, 32'hBE22_DE44, 1'b0);
      wr_chk("wr_dst_strb0", 23'h166040, 32'hFFFF_FFFF, 4'h0, 1, 1'b0);
      chk("dst_strb0", dst_ctrl, 32'hBE22_DE44);

      core_time = 64'h0000_0001_FFFF_FFFF;
      rd_chk("rd_ct_lo", 23'h166048, 32'hFFFF_FFFF, 1'b0);
      core_time = 64'h0000_0002_0000_0005;
      rd_chk("rd_ct_hi", 23'h16604C, 32'h0000_0001, 1'b0);
      rd_chk("rd_ct_lo2", 23'h166048, 32'h0000_0005, 1'b0);
      rd_chk("rd_ct_hi2", 23'h16604C, 32'h0000_0002, 1'b0);

      wr_chk("err_wr_id", 23'h000240, 32'h1234_5678, 4'hF, 1, 1'b1);
      rd_chk("rd_id_after", 23'h000240, 32'hDFD0_0001, 1'b0);
      wr_chk("err_wr_cthi", 23'h16604C, 32'h1234_5678, 4'hF, 1, 1'b1);
      rd_chk("rd_cthi_after", 23'h16604C, 32'h0000_0002, 1'b0);
      rd_chk("err_rd_250", 23'h000250, 32'h0, 1'b1);
      wr_chk("err_wr_250", 23'h000250, 32'h0BAD_0BAD, 4'hF, 1, 1'b1);
      rd_chk("err_rd_24a", 23'h00024A, 32'h0, 1'b1);
      wr_chk("err_wr_24a", 23'h00024A, 32'h0BAD_0BAD, 4'hF, 1, 1'b1);
      wr_chk("err_wr_alias", 23'h400248, 32'h0BAD_0BAD, 4'hF, 1, 1'b1);
      rd_chk("rd_s0_after_err", 23'h000248, 32'hDEAD_BEEF, 1'b0);
      rd_chk("rd_s1_after_err", 23'h00024C, 32'h0, 1'b0);
      chk("dst_after_err", dst_ctrl, 32'hBE22_DE44);

      wr_chk("wr_s1", 23'h00024C, 32'h0000_0055, 4'hF, 1, 1'b0);
      rd_chk("rd_s1_55", 23'h00024C, 32'h0000_0055, 1'b0);
      // Setup phase of a write, then reset held across the would-be access edge.
      paddr = 23'h00024C; pwrite = 1'b1; pwdata = 32'h0000_00AA; pstrb = 4'hF;
      psel = 1'b1; penable = 1'b0;
      @(posedge clk); #1;
      reset = 1'b1; penable = 1'b1;
      #1 chk("rst_mid_dst", dst_ctrl, 32'h0);
      @(posedge clk); #1;
      psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
      reset = 1'b0;
      @(posedge clk); #1;
      $display("xfer rst_abort addr=00024c wr=1 aborted by reset");
      rd_chk("rd_s1_abort", 23'h00024C, 32'h0, 1'b0);
      rd_chk("rd_s0_abort", 23'h000248, 32'h0, 1'b0);
      rd_chk("rd_cthi_abort", 23'h16604C, 32'h0, 1'b0);
      chk("dst_abort", dst_ctrl, 32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got no finish expected finish");
      $fatal(1, "timeout");
   end
endmodule
